// File: rtl/qed_dup_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// qed_sched_pkg
// Shared types and constants for the SQED duplicate-phase scheduler:
//   sched_state_t : round phase ORIG -> DUP -> DRAIN -> CHECK (2-bit, 0..3)
//   CNT_W_DEF     : default width of the original/duplicate counters
//   drain_w()     : width needed for a drain timer holding 0..depth
// -----------------------------------------------------------------------------
package qed_sched_pkg;

   typedef enum logic [1:0] {
      ORIG  = 2'd0,
      DUP   = 2'd1,
      DRAIN = 2'd2,
      CHECK = 2'd3
   } sched_state_t;

   localparam int CNT_W_DEF      = 8;
   localparam int PIPE_DEPTH_DEF = 5;

   // Width of a down-counter that must hold the value 'depth'.
   function automatic int drain_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int DRAIN_W_DEF = $clog2(PIPE_DEPTH_DEF + 1);

endpackage

// File: rtl/qed_dup_scheduler_if.sv
// -----------------------------------------------------------------------------
// qed_dup_scheduler_if
// Fetch-side signal bundle of the SQED duplicate scheduler.
//   PC_write, qed_vld_out, dup_req        : into the scheduler
//   qed_exec_dup, qed_stall_req,
//   qed_check_valid, orig_cnt, dup_cnt     : out of the scheduler
// Modports: slave = scheduler, master = fetch/hazard side driving it.
// -----------------------------------------------------------------------------
import qed_sched_pkg::*;

interface qed_dup_scheduler_if #(
   parameter int CNT_W = CNT_W_DEF
);
   logic             PC_write;
   logic             qed_vld_out;
   logic             dup_req;
   logic             qed_exec_dup;
   logic             qed_stall_req;
   logic             qed_check_valid;
   logic [CNT_W-1:0] orig_cnt;
   logic [CNT_W-1:0] dup_cnt;

   modport slave (
      input  PC_write, qed_vld_out, dup_req,
      output qed_exec_dup, qed_stall_req, qed_check_valid, orig_cnt, dup_cnt
   );

   modport master (
      output PC_write, qed_vld_out, dup_req,
      input  qed_exec_dup, qed_stall_req, qed_check_valid, orig_cnt, dup_cnt
   );
endinterface

// File: rtl/qed_dup_scheduler_drain_timer.sv
// -----------------------------------------------------------------------------
// qed_drain_timer
// Load/decrement down-counter used to wait out the pipeline after the last
// duplicate issue.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (has priority over dec)
//   load_val   : drain length in cycles
//   dec        : decrement by one (stops at zero)
//   done       : counter currently holds 1, i.e. this is the last drain cycle
// -----------------------------------------------------------------------------
import qed_sched_pkg::*;

module qed_drain_timer #(
   parameter int W = DRAIN_W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         done
);
   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else if (load)
         cnt_q <= load_val;
      else if (dec && (cnt_q != '0))
         cnt_q <= cnt_q - W'(1);
   end

   assign done = (cnt_q == W'(1));
endmodule

// File: rtl/qed_dup_scheduler.sv
// -----------------------------------------------------------------------------
// qed_dup_scheduler
// Sequences the SQED original/duplicate fetch phases. Originals are counted in
// ORIG, the same number of duplicates in DUP, then fetch is held for
// PIPE_DEPTH cycles (DRAIN) and a one-cycle CHECK pulse marks the register
// halves as comparable before the next round starts.
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : PC_write, qed_vld_out, dup_req in;
//                     qed_exec_dup, qed_stall_req, qed_check_valid,
//                     orig_cnt, dup_cnt out
// Optional build macro: QED_SCHED_AUTO_EN -- leave ORIG automatically once the
// original count reaches AUTO_THRESH.
// -----------------------------------------------------------------------------
import qed_sched_pkg::*;

module qed_dup_scheduler #(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int PIPE_DEPTH  = PIPE_DEPTH_DEF,
   parameter int AUTO_THRESH = 16
) (
   input logic                clk,
   input logic                reset,
   qed_dup_scheduler_if.slave bus
);
   localparam int               TMR_W   = drain_w(PIPE_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef QED_SCHED_AUTO_EN
   localparam bit AUTO_ON = 1'b1;
`else
   localparam bit AUTO_ON = 1'b0;
`endif

   sched_state_t     state_q, state_d;
   logic [CNT_W-1:0] orig_q, orig_d, orig_nxt;
   logic [CNT_W-1:0] dup_q, dup_d, dup_nxt;
   logic             stall, issue, auto_hit;
   logic             tmr_load, tmr_dec, tmr_done;

   // Saturating increment: the original count must never wrap to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   assign stall    = (state_q == DRAIN) || (state_q == CHECK);
   assign issue    = bus.qed_vld_out & bus.PC_write & ~stall;
   assign orig_nxt = issue ? sat_inc(orig_q) : orig_q;
   assign dup_nxt  = issue ? dup_q + CNT_W'(1) : dup_q;
   assign auto_hit = AUTO_ON && (32'(orig_nxt) >= 32'(AUTO_THRESH));
   assign tmr_dec  = (state_q == DRAIN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ORIG;
         orig_q  <= '0;
         dup_q   <= '0;
      end else begin
         state_q <= state_d;
         orig_q  <= orig_d;
         dup_q   <= dup_d;
      end
   end

   // Issues are counted against the current mode, even on a transition cycle.
   always_comb begin
      state_d  = state_q;
      orig_d   = orig_q;
      dup_d    = dup_q;
      tmr_load = 1'b0;
      case (state_q)
         ORIG: begin
            orig_d = orig_nxt;
            // A request with nothing issued is ignored so exec_dup cannot
            // toggle while orig_cnt is zero.
            if ((bus.dup_req && (orig_nxt != '0)) || (orig_nxt == CNT_MAX) || auto_hit)
               state_d = DUP;
         end
         DUP: begin
            dup_d = dup_nxt;
            if (dup_nxt == orig_q) begin
               state_d  = DRAIN;
               tmr_load = 1'b1;
            end
         end
         DRAIN: begin
            if (tmr_done)
               state_d = CHECK;
         end
         CHECK: begin
            state_d = ORIG;
            orig_d  = '0;
            dup_d   = '0;
         end
         default: state_d = ORIG;
      endcase
   end

   qed_drain_timer #(.W(TMR_W)) u_drain_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (TMR_W'(PIPE_DEPTH)),
      .dec      (tmr_dec),
      .done     (tmr_done)
   );

   assign bus.qed_exec_dup    = (state_q != ORIG);
   assign bus.qed_stall_req   = stall;
   assign bus.qed_check_valid = (state_q == CHECK);
   assign bus.orig_cnt        = orig_q;
   assign bus.dup_cnt         = dup_q;
endmodule

// File: tb/tb_qed_dup_scheduler.sv
// -----------------------------------------------------------------------------
// tb_qed_dup_scheduler
// Bench for qed_dup_scheduler. Instance A (CNT_W=8, PIPE_DEPTH=5) is driven
// cycle by cycle; a reference model pushes the expected outputs into a
// scoreboard queue as each stimulus is applied and they are popped and
// compared after the clock edge. Instance B (CNT_W=3, PIPE_DEPTH=2,
// AUTO_THRESH=4) covers counter saturation and, with QED_SCHED_AUTO_EN,
// the automatic switch to DUP.
// -----------------------------------------------------------------------------
module tb_qed_dup_scheduler;

`ifdef QED_SCHED_AUTO_EN
   localparam bit AUTO_ON_TB = 1'b1;
`else
   localparam bit AUTO_ON_TB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_a, rst_b;

   always #5 clk = ~clk;

   qed_dup_scheduler_if #(.CNT_W(8)) bus_a ();
   qed_dup_scheduler_if #(.CNT_W(3)) bus_b ();

   qed_dup_scheduler #(.CNT_W(8), .PIPE_DEPTH(5), .AUTO_THRESH(16)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (bus_a)
   );

   qed_dup_scheduler #(.CNT_W(3), .PIPE_DEPTH(2), .AUTO_THRESH(4)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (bus_b)
   );

   typedef struct {
      logic       exec;
      logic       stall;
      logic       chkv;
      logic [7:0] orig;
      logic [7:0] dup;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   // Reference model state for instance A: 0 ORIG, 1 DUP, 2 DRAIN, 3 CHECK.
   int m_st = 0, m_orig = 0, m_dup = 0, m_tmr = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive_a(input logic r, input logic pcw, input logic vld, input logic req);
      exp_t e;
      logic iss;
      int   on, dn;
      rst_a             = r;
      bus_a.PC_write    = pcw;
      bus_a.qed_vld_out = vld;
      bus_a.dup_req     = req;
      iss = vld && pcw && (m_st < 2);
      if (r) begin
         m_st = 0; m_orig = 0; m_dup = 0; m_tmr = 0;
      end else begin
         case (m_st)
            0: begin
               on = iss ? ((m_orig == 255) ? 255 : m_orig + 1) : m_orig;
               m_orig = on;
               if ((req && on != 0) || on == 255 || (AUTO_ON_TB && on >= 16)) m_st = 1;
            end
            1: begin
               dn = m_dup + (iss ? 1 : 0);
               m_dup = dn;
               if (dn == m_orig) begin m_st = 2; m_tmr = 5; end
            end
            2: begin
               if (m_tmr == 1) m_st = 3;
               else m_tmr--;
            end
            default: begin m_st = 0; m_orig = 0; m_dup = 0; end
         endcase
      end
      e.exec  = (m_st != 0);
      e.stall = (m_st >= 2);
      e.chkv  = (m_st == 3);
      e.orig  = 8'(m_orig);
      e.dup   = 8'(m_dup);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_eq("a_exec_dup", bus_a.qed_exec_dup, e.exec);
      check_eq("a_stall_req", bus_a.qed_stall_req, e.stall);
      check_eq("a_check_valid", bus_a.qed_check_valid, e.chkv);
      check_eq("a_orig_cnt", bus_a.orig_cnt, e.orig);
      check_eq("a_dup_cnt", bus_a.dup_cnt, e.dup);
   endtask

   task automatic drive_b(input logic r, input logic vld);
      rst_b             = r;
      bus_b.PC_write    = 1'b1;
      bus_b.qed_vld_out = vld;
      bus_b.dup_req     = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      bus_a.PC_write = 1'b0; bus_a.qed_vld_out = 1'b0; bus_a.dup_req = 1'b0;
      bus_b.PC_write = 1'b0; bus_b.qed_vld_out = 1'b0; bus_b.dup_req = 1'b0;

      // Reset state
      drive_a(1, 0, 0, 0);
      drive_a(1, 0, 0, 0);
      check_eq("rst_exec", bus_a.qed_exec_dup, 0);
      check_eq("rst_stall", bus_a.qed_stall_req, 0);

      // Full round: 3 originals, request, 3 duplicates, drain, check
      repeat (3) drive_a(0, 1, 1, 0);
      check_eq("orig_3", bus_a.orig_cnt, 3);
      drive_a(0, 1, 0, 1);
      check_eq("exec_after_req", bus_a.qed_exec_dup, 1);
      repeat (3) drive_a(0, 1, 1, 0);
      check_eq("drain_stall_0", bus_a.qed_stall_req, 1);
      check_eq("drain_chk_0", bus_a.qed_check_valid, 0);
      for (int i = 1; i < 5; i++) begin
         drive_a(0, 1, 1, 0);
         check_eq("drain_stall", bus_a.qed_stall_req, 1);
         check_eq("drain_chk", bus_a.qed_check_valid, 0);
         check_eq("drain_dup_frozen", bus_a.dup_cnt, 3);
      end
      drive_a(0, 1, 1, 0);
      check_eq("check_pulse", bus_a.qed_check_valid, 1);
      drive_a(0, 1, 0, 0);
      check_eq("post_chk_valid", bus_a.qed_check_valid, 0);
      check_eq("post_chk_exec", bus_a.qed_exec_dup, 0);
      check_eq("post_chk_orig", bus_a.orig_cnt, 0);

      // Request with nothing issued is ignored
      repeat (10) drive_a(0, 1, 0, 1);
      check_eq("idle_req_exec", bus_a.qed_exec_dup, 0);

      // Reset mid-DUP with orig=3, dup=1
      repeat (3) drive_a(0, 1, 1, 0);
      drive_a(0, 1, 0, 1);
      drive_a(0, 1, 1, 0);
      check_eq("middup_dup", bus_a.dup_cnt, 1);
      drive_a(1, 1, 1, 1);
      check_eq("middup_rst_exec", bus_a.qed_exec_dup, 0);
      check_eq("middup_rst_orig", bus_a.orig_cnt, 0);
      check_eq("middup_rst_dup", bus_a.dup_cnt, 0);

      // PC_write low during DUP freezes dup_cnt but not the drain timer
      repeat (2) drive_a(0, 1, 1, 0);
      drive_a(0, 1, 0, 1);
      drive_a(0, 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         drive_a(0, 0, 1, 0);
         check_eq("pcw_low_dup", bus_a.dup_cnt, 1);
      end
      drive_a(0, 1, 1, 0);
      check_eq("pcw_resume_dup", bus_a.dup_cnt, 2);
      repeat (4) drive_a(0, 0, 1, 0);
      drive_a(0, 0, 1, 0);
      check_eq("pcw_low_check", bus_a.qed_check_valid, 1);
      drive_a(0, 1, 0, 0);

      // Random traffic through the scoreboard
      for (int i = 0; i < 400; i++)
         drive_a($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);

      // Narrow instance: saturation / automatic switch
      drive_b(1, 0);
      drive_b(1, 0);
      check_eq("b_rst_orig", bus_b.orig_cnt, 0);
      check_eq("b_rst_exec", bus_b.qed_exec_dup, 0);
      for (int i = 1; i <= 7; i++) begin
         drive_b(0, 1);
         if (AUTO_ON_TB) begin
            check_eq("b_orig", bus_b.orig_cnt, (i > 4) ? 4 : i);
            check_eq("b_exec", bus_b.qed_exec_dup, i >= 4);
            check_eq("b_dup", bus_b.dup_cnt, (i > 4) ? i - 4 : 0);
         end else begin
            check_eq("b_orig", bus_b.orig_cnt, i);
            check_eq("b_exec", bus_b.qed_exec_dup, i >= 7);
            check_eq("b_dup", bus_b.dup_cnt, 0);
         end
      end
      drive_b(0, 1);
      check_eq("b_no_wrap", bus_b.orig_cnt, AUTO_ON_TB ? 4 : 7);
      check_eq("b_exec_hold", bus_b.qed_exec_dup, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
